seg_scan_driver: RTL

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It advances a 2-bit digit-scan index (mod-4 wrap) from an internal clock-enable prescaler. Each cycle it drives the selected digit's anode and its decoded hex pattern. It sits downstream of the 2-bit counting stage and consumes a 16-bit display word loaded by upstream logic.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/hex_to_7seg.sv | 14 +
 rtl/seg_scan_driver.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// digit count, blank pattern, hex decode table and leading-zero mask.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex nibble value
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Bit i set when nibbles i..3 are all zero; digit 0 is never blanked
  function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input logic [15:0] value);
    logic [NUM_DIGITS-1:0] mask;
    mask[3] = (value[15:12] == 4'h0);
    mask[2] = mask[3] && (value[11:8] == 4'h0);
    mask[1] = mask[2] && (value[7:4] == 4'h0);
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup of the segment pattern
  always_comb begin
    seg_n = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with a
// clock-enable prescaler, shadowed display word and registered outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_COUNT = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [15:0]           value_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [1:0]            digit_sel,
  output logic                  scan_tick
);

  // DIV_COUNT may equal 2**DIV_WIDTH, so only the terminal count is stored
  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(DIV_COUNT - 1);

  logic [DIV_WIDTH-1:0]  presc_q, presc_d;
  logic [1:0]            digit_sel_q, digit_sel_d;
  logic                  scan_tick_q, scan_tick_d;
  logic [15:0]           shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] blank_mask;

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  // Nibble select for the digit currently being scanned
  always_comb begin
    cur_nibble = 4'h0;
    case (digit_sel_q)
      2'd0:    cur_nibble = shadow_val_q[3:0];
      2'd1:    cur_nibble = shadow_val_q[7:4];
      2'd2:    cur_nibble = shadow_val_q[11:8];
      2'd3:    cur_nibble = shadow_val_q[15:12];
      default: cur_nibble = 4'h0;
    endcase
  end

  // Next-state for prescaler, scan index, shadow and display registers
  always_comb begin
    presc_d      = presc_q;
    digit_sel_d  = digit_sel_q;
    scan_tick_d  = 1'b0;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    blank_mask   = lz_blank_mask(shadow_val_q);

    if (presc_q == PRESC_LAST) begin
      presc_d     = {DIV_WIDTH{1'b0}};
      digit_sel_d = digit_sel_q + 2'd1;
      scan_tick_d = 1'b1;
    end else begin
      presc_d     = presc_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end

    if (load) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
    end else begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
    end

    an_d = ~(4'b0001 << digit_sel_q);
    dp_d = ~shadow_dp_q[digit_sel_q];
    if (blank_lz && blank_mask[digit_sel_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q      <= {DIV_WIDTH{1'b0}};
      digit_sel_q  <= 2'd0;
      scan_tick_q  <= 1'b0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      digit_sel_q  <= digit_sel_d;
      scan_tick_q  <= scan_tick_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = digit_sel_q;
  assign scan_tick = scan_tick_q;

endmodule
